// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic valid/ready pipeline register between CPU stages.
// Define PIPE_STAGE_SKID_EN to add a skid entry so in_ready no longer depends on out_ready.
module pipe_stage_reg #(
  parameter int                 DATA_W   = 96,
  parameter int                 CTRL_W   = 24,
  parameter logic [CTRL_W-1:0]  NOP_CTRL = '0,
  parameter int                 CNT_W    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Encoding equals the number of held entries, so occupancy is the state itself.
`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;
`else
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1} state_e;
`endif

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
`ifdef PIPE_STAGE_SKID_EN
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
`endif
  logic                in_fire;
  logic                out_fire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) return v;
    return v + CNT_W'(1);
  endfunction

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_data_q;
  assign out_ctrl  = main_ctrl_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_cnt_q;

`ifdef PIPE_STAGE_SKID_EN
  assign in_ready = !RST && !flush && (state_q != FULL);
`else
  assign in_ready = !RST && !flush && (!out_valid || out_ready);
`endif

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
`endif
    if (flush) begin
      // Squash wins over any acceptance; an out-fire this cycle has already been consumed.
      state_d     = EMPTY;
      main_data_d = '0;
      main_ctrl_d = NOP_CTRL;
`ifdef PIPE_STAGE_SKID_EN
      skid_data_d = '0;
      skid_ctrl_d = NOP_CTRL;
`endif
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d     = ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (in_fire) begin
`ifdef PIPE_STAGE_SKID_EN
            state_d     = FULL;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
`endif
          end else if (out_fire) begin
            state_d     = EMPTY;
            main_data_d = '0;
            main_ctrl_d = NOP_CTRL;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        FULL: begin
          if (out_fire) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            skid_data_d = '0;
            skid_ctrl_d = NOP_CTRL;
          end
        end
`endif
        default: begin
          state_d     = EMPTY;
          main_data_d = '0;
          main_ctrl_d = NOP_CTRL;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready) stall_cnt_d = sat_inc(stall_cnt_q);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= NOP_CTRL;
      stall_cnt_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_data_q <= '0;
      skid_ctrl_q <= NOP_CTRL;
`endif
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      stall_cnt_q <= stall_cnt_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_stage_reg;
  localparam int              DW      = 16;
  localparam int              CW      = 8;
  localparam int              CNTW    = 4;
  localparam logic [CW-1:0]   NOP     = 8'h5A;
  localparam int              CNT_MAX = (1 << CNTW) - 1;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_data = '0;
  logic [CW-1:0]   in_ctrl = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_data;
  logic [CW-1:0]   out_ctrl;
  logic [1:0]      occupancy;
  logic [CNTW-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } entry_t;

  entry_t mq[$];
  int     mcnt = 0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .NOP_CTRL(NOP), .CNT_W(CNTW)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_rdy();
    if (RST || flush) return 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    return mq.size() < 2;
`else
    return (mq.size() == 0) || out_ready;
`endif
  endfunction

  // Reference model: a bounded FIFO advanced on each clock edge.
  initial forever begin
    @(posedge CLK or posedge RST);
    if (RST) begin
      mq.delete();
      mcnt = 0;
    end else begin
      bit inf, outf;
      inf  = in_valid && exp_rdy();
      outf = (mq.size() > 0) && out_ready;
      if (mq.size() > 0 && !out_ready && mcnt < CNT_MAX) mcnt++;
      if (flush) mq.delete();
      else begin
        if (outf) void'(mq.pop_front());
        if (inf) mq.push_back('{d: in_data, c: in_ctrl});
      end
    end
  end

  // Compare process: all outputs against the model, every cycle.
  initial forever begin
    logic            ev;
    logic [DW-1:0]   ed;
    logic [CW-1:0]   ec;
    @(negedge CLK);
    #2;
    ev = (mq.size() > 0);
    ed = ev ? mq[0].d : '0;
    ec = ev ? mq[0].c : NOP;
    chk("m_out_valid", 64'(out_valid), 64'(ev));
    chk("m_out_data",  64'(out_data),  64'(ed));
    chk("m_out_ctrl",  64'(out_ctrl),  64'(ec));
    chk("m_occupancy", 64'(occupancy), 64'(mq.size()));
    chk("m_stall_cnt", 64'(stall_cnt), 64'(mcnt));
    chk("m_in_ready",  64'(in_ready),  64'(exp_rdy()));
  end

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_valid = v;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin
    repeat (2) @(negedge CLK);
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_ctrl",  64'(out_ctrl),  64'h5A);
    chk("rst_in_ready",  64'(in_ready),  64'h0);
    @(negedge CLK);
    RST = 1'b0;
    #3 chk("rdy_after_reset", 64'(in_ready), 64'h1);

    // Streaming 1,2,3
    @(negedge CLK); drive(1'b1, 16'h1, 8'h11); out_ready = 1'b1;
    @(negedge CLK); drive(1'b1, 16'h2, 8'h12);
    #3 chk("stream_d1", 64'(out_data), 64'h1); chk("stream_c1", 64'(out_ctrl), 64'h11);
    chk("stream_occ", 64'(occupancy), 64'h1);
    @(negedge CLK); drive(1'b1, 16'h3, 8'h13);
    #3 chk("stream_d2", 64'(out_data), 64'h2);
    @(negedge CLK); in_valid = 1'b0;
    #3 chk("stream_d3", 64'(out_data), 64'h3);
    @(negedge CLK);
    #3 chk("stream_drained", 64'(out_valid), 64'h0);
    chk("stream_nop_data", 64'(out_data), 64'h0);

`ifdef PIPE_STAGE_SKID_EN
    @(negedge CLK); drive(1'b1, 16'hA, 8'h0A); out_ready = 1'b0;
    @(negedge CLK); drive(1'b1, 16'hB, 8'h0B);
    #3 chk("skid_head_A", 64'(out_data), 64'hA);
    @(negedge CLK); in_valid = 1'b0;
    #3 chk("skid_occ2", 64'(occupancy), 64'h2);
    chk("skid_rdy0", 64'(in_ready), 64'h0);
    chk("skid_hold_A", 64'(out_data), 64'hA);
    @(negedge CLK);
    @(negedge CLK);
    #3 chk("skid_stall3", 64'(stall_cnt), 64'h3);
    out_ready = 1'b1;
    @(negedge CLK);
    #3 chk("skid_then_B", 64'(out_data), 64'hB);
    chk("skid_rdy1", 64'(in_ready), 64'h1);
    chk("skid_occ1", 64'(occupancy), 64'h1);
    @(negedge CLK);
    #3 chk("skid_empty", 64'(out_valid), 64'h0);

    @(negedge CLK); drive(1'b1, 16'hA, 8'h0A); out_ready = 1'b0;
    @(negedge CLK); drive(1'b1, 16'hB, 8'h0B);
    @(negedge CLK); drive(1'b1, 16'hC, 8'h0C); flush = 1'b1;
    #1 chk("flush_full", 64'(occupancy), 64'h2);
    chk("flush_rdy0", 64'(in_ready), 64'h0);
`else
    @(negedge CLK); drive(1'b1, 16'h5, 8'h05); out_ready = 1'b0;
    @(negedge CLK); drive(1'b1, 16'h6, 8'h06);
    #3 chk("nskid_rdy0", 64'(in_ready), 64'h0);
    chk("nskid_hold5", 64'(out_data), 64'h5);
    out_ready = 1'b1;
    #1 chk("nskid_rdy_comb", 64'(in_ready), 64'h1);
    @(negedge CLK); in_valid = 1'b0;
    #3 chk("nskid_load6", 64'(out_data), 64'h6);
    chk("nskid_ctrl6", 64'(out_ctrl), 64'h06);
    out_ready = 1'b0;
    @(negedge CLK); drive(1'b1, 16'hC, 8'h0C); flush = 1'b1;
    #1 chk("flush_rdy0", 64'(in_ready), 64'h0);
`endif
    @(negedge CLK); flush = 1'b0; in_valid = 1'b0;
    #3 chk("flush_valid0", 64'(out_valid), 64'h0);
    chk("flush_occ0", 64'(occupancy), 64'h0);
    chk("flush_nop", 64'(out_ctrl), 64'h5A);
    out_ready = 1'b1;
    repeat (3) @(negedge CLK);
    #3 chk("flush_C_dropped", 64'(out_valid), 64'h0);

    // Saturation: 20 stalled cycles on a 4-bit counter
    @(negedge CLK); drive(1'b1, 16'h7, 8'h07); out_ready = 1'b0;
    @(negedge CLK); in_valid = 1'b0;
    repeat (20) @(negedge CLK);
    #3 chk("stall_sat", 64'(stall_cnt), 64'd15);

    // Asynchronous reset mid-cycle with an entry held
    @(negedge CLK);
    #1 RST = 1'b1;
    #1 chk("arst_valid", 64'(out_valid), 64'h0);
    chk("arst_data", 64'(out_data), 64'h0);
    chk("arst_ctrl", 64'(out_ctrl), 64'h5A);
    chk("arst_rdy", 64'(in_ready), 64'h0);
    chk("arst_cnt", 64'(stall_cnt), 64'h0);
    @(negedge CLK); RST = 1'b0; drive(1'b1, 16'h44, 8'h44); out_ready = 1'b1;
    @(negedge CLK); in_valid = 1'b0;
    #3 chk("arst_first_accept", 64'(out_data), 64'h44);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      @(negedge CLK);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom);
      in_ctrl   = CW'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      RST       = ($urandom_range(0, 149) == 0);
    end
    @(negedge CLK);
    RST = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge CLK);
    #3 chk("final_empty", 64'(out_valid), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline-stage register used between every pair of CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It replaces the fixed-field stall buffers with one generic block. A payload bus and a control bus move through a valid/ready handshake. When the stage holds nothing, the block presents a NOP control word and a zero payload. It supports synchronous flush for branch/jump squash and an optional 2-entry skid that registers `in_ready`.

## Interface
- `DATA_W`, 96: payload width (PC+4, operands, immediate, …).
- `CTRL_W`, 24: control-bundle width (ALUOp, MemRead, RegWrite, …).
- `NOP_CTRL`, 0: control word presented when `out_valid`=0 (bubble encoding).
- `CNT_W`, 16: width of the stall counter.
- `CLK` in 1: clock; all state updates on rising edge.
- `RST` in 1: reset; asynchronous, active-high.
- `flush` in 1: synchronous squash of all held entries.
- `in_valid` in 1: upstream entry present.
- `in_ready` out 1: block accepts an entry this cycle.
- `in_data` in DATA_W: upstream payload.
- `in_ctrl` in CTRL_W: upstream control bundle.
- `out_valid` out 1: downstream entry present.
- `out_ready` in 1: downstream accepts; low = stall.
- `out_data` out DATA_W: held payload; 0 when invalid.
- `out_ctrl` out CTRL_W: held control; `NOP_CTRL` when invalid.
- `occupancy` out 2: entries held (0, 1, or 2).
- `stall_cnt` out CNT_W: saturating count of cycles with `out_valid`=1 and `out_ready`=0.

## Operation
- Terms:
  - in-fire = `in_valid` && `in_ready`.
  - out-fire = `out_valid` && `out_ready`.
- Storage: a main register drives the outputs; a skid register exists only with the macro enabled.
- States: EMPTY (occ 0), ONE (main valid, occ 1), FULL (main+skid valid, occ 2; macro only).
- EMPTY:
  - in-fire → ONE, main ← in.
  - otherwise stay.
- ONE:
  - in-fire & out-fire → ONE, main ← in.
  - in-fire & !out-fire:
    - macro on: FULL, skid ← in.
    - macro off: cannot occur (`in_ready`=0).
  - !in-fire & out-fire → EMPTY.
  - neither: hold.
- FULL:
  - `in_ready`=0.
  - out-fire → ONE, main ← skid.
  - otherwise hold.
- Order is preserved. Data and control pass unmodified; no entry is duplicated or dropped except by flush.
- `flush`=1 has priority over everything:
  - Next state is EMPTY, and main/skid are cleared (data 0, ctrl `NOP_CTRL`).
  - `in_ready` is forced 0 that cycle, so no input is accepted.
  - An out-fire in the flush cycle is still a valid transfer.
- Reset:
  - State EMPTY.
  - `out_valid`=0, `out_data`=0, `out_ctrl`=`NOP_CTRL`, `occupancy`=0, `stall_cnt`=0.
  - `in_ready`=0 while `RST` is high.
- `stall_cnt`:
  - Increments each edge with `out_valid` && !`out_ready`.
  - Saturates at 2^CNT_W−1.
  - Cleared only by `RST`; unaffected by flush.

## Timing
- Latency: in-fire at edge N → `out_valid`=1 with that entry after edge N, when EMPTY or ONE-with-out-fire.
- Throughput: one entry per cycle in both modes while `out_ready`=1.
- `out_valid`, `out_data`, `out_ctrl`, `occupancy`, and `stall_cnt` are registered outputs only.
- RST asserted mid-transfer: outputs take reset values immediately, without waiting for an edge. The first acceptance is possible at the first edge after RST deasserts.
- `in_valid` must not depend combinationally on `in_ready`.

## Configuration
- `PIPE_STAGE_SKID_EN` defined:
  - Skid register and FULL state are present.
  - `in_ready` = !skid_valid && !flush, with no combinational path from `out_ready`.
  - `occupancy` reaches 2.
- `PIPE_STAGE_SKID_EN` undefined:
  - Single entry only.
  - `in_ready` = (!`out_valid` || `out_ready`) && !`flush`, which is combinational from `out_ready`.
  - `occupancy` ≤ 1.

## Test plan
- Reset: RST=1 asynchronously mid-cycle → `out_valid`=0, `out_ctrl`=`NOP_CTRL`, `out_data`=0, `in_ready`=0. Release → `in_ready`=1.
- Streaming: `out_ready`=1, inputs 0x1,0x2,0x3 on consecutive cycles → outputs 0x1,0x2,0x3 on the next three cycles, one cycle later; `occupancy`=1.
- Stall with skid enabled: load 0xA then 0xB with `out_ready`=0 → `occupancy`=2, `in_ready`=0, `out_data`=0xA held. Hold 3 cycles → `stall_cnt`=3. Raise `out_ready` → 0xA then 0xB, `in_ready` back to 1.
- Stall without skid: `out_ready`=0, entry 0x5 held → `in_ready`=0 in the same cycle. `out_ready`=1 with `in_valid`=1 carrying 0x6 → 0x6 loads next edge.
- Flush: FULL with 0xA/0xB, pulse `flush` with `in_valid`=1 carrying 0xC → next cycle `out_valid`=0, `occupancy`=0, `out_ctrl`=`NOP_CTRL`, and 0xC is never output.
- Saturation: CNT_W=4, stall 20 cycles → `stall_cnt`=15.
